iiitb_duty_btn_ctrl: RTL and testbench

Upstream front-end for iiitb_pwm_gen. Takes two raw, asynchronous, bouncy push-button inputs (duty up / duty down). Synchronises and debounces each button, then converts each press into clean single-cycle pulses that drive iiitb_pwm_gen's increase_duty / decrease_duty. Optional hold-to-auto-repeat. Conflicting simultaneous presses are rejected so the PWM stage never sees both requests at once.

---
 rtl/iiitb_duty_btn_ctrl_pkg.sv | 17 +
 rtl/iiitb_btn_debounce.sv | 41 ++++
 rtl/iiitb_duty_btn_ctrl.sv | 133 +++++++++++++
 tb/tb_iiitb_duty_btn_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_duty_btn_ctrl_pkg.sv
// Shared constants for the duty button front-end and PWM stage.
// Defaults assume a 100 MHz system clock.
package iiitb_duty_btn_ctrl_pkg;

   localparam int unsigned DEF_DB_CYCLES     = 1000000;
   localparam int unsigned DEF_REPEAT_EN     = 1;
   localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
   localparam int unsigned DEF_REPEAT_PERIOD = 20000000;
   localparam int unsigned DEF_CNT_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT
   } press_st_t;

endpackage

// File: rtl/iiitb_btn_debounce.sv
// Two-flop synchroniser followed by a stable-level debounce counter.
// The accepted level only flips after DB_CYCLES consecutive differing cycles.
module iiitb_btn_debounce
   import iiitb_duty_btn_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic db
);

   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         db  <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_TOP) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/iiitb_duty_btn_ctrl.sv
// Button front-end for iiitb_pwm_gen: debounce, press pulses,
// hold-to-repeat and mutual suppression of up/down requests.
module iiitb_duty_btn_ctrl
   import iiitb_duty_btn_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
   parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up_raw,
   input  logic btn_dn_raw,
   output logic increase_duty,
   output logic decrease_duty,
   output logic btn_up_db,
   output logic btn_dn_db
);

   localparam logic [CNT_W-1:0] DLY_TOP =
      CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_TOP =
      CNT_W'(REPEAT_PERIOD - 1);
   localparam logic REP = (REPEAT_EN != 0);

   logic [1:0]       db;
   press_st_t        st_q  [2];
   press_st_t        st_d  [2];
   logic [CNT_W-1:0] tmr_q [2];
   logic [CNT_W-1:0] tmr_d [2];
   logic [1:0]       fire;
   logic [1:0]       pls_d;
   logic [1:0]       pls_q;

   iiitb_btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_db_up (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_up_raw),
      .db    (db[0])
   );

   iiitb_btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_db_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_dn_raw),
      .db    (db[1])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            st_q[c]  <= ST_IDLE;
            tmr_q[c] <= '0;
         end
         pls_q <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            st_q[c]  <= st_d[c];
            tmr_q[c] <= tmr_d[c];
         end
         pls_q <= pls_d;
      end
   end

   // A release always wins over a repeat due in the same cycle.
   always_comb begin
      fire = '0;
      for (int c = 0; c < 2; c++) begin
         st_d[c]  = st_q[c];
         tmr_d[c] = tmr_q[c];
         unique case (st_q[c])
            ST_IDLE: begin
               if (db[c]) begin
                  st_d[c]  = ST_HOLD;
                  tmr_d[c] = '0;
                  fire[c]  = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!db[c]) begin
                  st_d[c]  = ST_IDLE;
                  tmr_d[c] = '0;
               end else if (tmr_q[c] == DLY_TOP) begin
                  tmr_d[c] = '0;
                  if (REP) begin
                     st_d[c] = ST_REPEAT;
                     fire[c] = 1'b1;
                  end
               end else begin
                  tmr_d[c] = tmr_q[c] + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (!db[c]) begin
                  st_d[c]  = ST_IDLE;
                  tmr_d[c] = '0;
               end else if (tmr_q[c] == PER_TOP) begin
                  tmr_d[c] = '0;
                  fire[c]  = 1'b1;
               end else begin
                  tmr_d[c] = tmr_q[c] + 1'b1;
               end
            end
            default: begin
               st_d[c]  = ST_IDLE;
               tmr_d[c] = '0;
            end
         endcase
      end
   end

   // A pulse can only fire while its own db is high, so the two
   // suppression terms make the outputs mutually exclusive.
   always_comb begin
      pls_d    = '0;
      pls_d[0] = fire[0] & ~db[1];
      pls_d[1] = fire[1] & ~db[0];
   end

   assign increase_duty = pls_q[0];
   assign decrease_duty = pls_q[1];
   assign btn_up_db     = db[0];
   assign btn_dn_db     = db[1];

endmodule

// File: tb/tb_iiitb_duty_btn_ctrl.sv
// Bench for iiitb_duty_btn_ctrl: directed timing plus random presses
// checked every cycle against a press-age reference model.
module tb_iiitb_duty_btn_ctrl;

   localparam int DB  = 4;
   localparam int DLY = 10;
   localparam int PER = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] raw   = 2'b00;

   logic inc0, dec0, updb0, dndb0;
   logic inc1, dec1, updb1, dndb1;

   int n_chk = 0;
   int n_err = 0;
   int n_inc0 = 0, n_dec0 = 0, n_inc1 = 0, n_dec1 = 0;

   always #5 clk = ~clk;

   iiitb_duty_btn_ctrl #(
      .DB_CYCLES     (DB),
      .REPEAT_EN     (0),
      .REPEAT_DELAY  (DLY),
      .REPEAT_PERIOD (PER),
      .CNT_W         (8)
   ) u_dut0 (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_up_raw    (raw[0]),
      .btn_dn_raw    (raw[1]),
      .increase_duty (inc0),
      .decrease_duty (dec0),
      .btn_up_db     (updb0),
      .btn_dn_db     (dndb0)
   );

   iiitb_duty_btn_ctrl #(
      .DB_CYCLES     (DB),
      .REPEAT_EN     (1),
      .REPEAT_DELAY  (DLY),
      .REPEAT_PERIOD (PER),
      .CNT_W         (8)
   ) u_dut1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_up_raw    (raw[0]),
      .btn_dn_raw    (raw[1]),
      .increase_duty (inc1),
      .decrease_duty (dec1),
      .btn_up_db     (updb1),
      .btn_dn_db     (dndb1)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // Reference model. age = edges since the accepted press, -1 idle.
   bit [1:0] m_s1, m_s2, m_db, pls0, pls1;
   int       m_run [2];
   int       age0  [2];
   int       age1  [2];

   function automatic bit fires(int age, bit lvl, bit rep);
      int a;
      if (!lvl) return 1'b0;
      if (age < 0) return 1'b1;
      a = age + 1;
      return rep && (a >= DLY) && (((a - DLY) % PER) == 0);
   endfunction

   function automatic int step_age(int age, bit lvl);
      if (!lvl) return -1;
      return age + 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 <= '0;
         m_s2 <= '0;
         m_db <= '0;
         pls0 <= '0;
         pls1 <= '0;
         for (int c = 0; c < 2; c++) begin
            m_run[c] <= 0;
            age0[c]  <= -1;
            age1[c]  <= -1;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            age0[c] <= step_age(age0[c], m_db[c]);
            age1[c] <= step_age(age1[c], m_db[c]);
            pls0[c] <= fires(age0[c], m_db[c], 1'b0) && !m_db[1-c];
            pls1[c] <= fires(age1[c], m_db[c], 1'b1) && !m_db[1-c];
            if (m_s2[c] != m_db[c]) begin
               if (m_run[c] + 1 == DB) begin
                  m_db[c]  <= m_s2[c];
                  m_run[c] <= 0;
               end else begin
                  m_run[c] <= m_run[c] + 1;
               end
            end else begin
               m_run[c] <= 0;
            end
            m_s2[c] <= m_s1[c];
            m_s1[c] <= raw[c];
         end
      end
   end

   always @(negedge clk) begin
      check("inc0", inc0, pls0[0]);
      check("dec0", dec0, pls0[1]);
      check("inc1", inc1, pls1[0]);
      check("dec1", dec1, pls1[1]);
      check("updb0", updb0, m_db[0]);
      check("dndb0", dndb0, m_db[1]);
      check("updb1", updb1, m_db[0]);
      check("dndb1", dndb1, m_db[1]);
      check("excl0", inc0 & dec0, 0);
      check("excl1", inc1 & dec1, 0);
      if (inc0) n_inc0 <= n_inc0 + 1;
      if (dec0) n_dec0 <= n_dec0 + 1;
      if (inc1) n_inc1 <= n_inc1 + 1;
      if (dec1) n_dec1 <= n_dec1 + 1;
   end

   initial begin
      int b0, b1, b2, b3;
      int nd, nsup, nres;
      logic prev_dn;

      repeat (3) @(negedge clk);
      check("rst_inc0", inc0, 0);
      check("rst_dec0", dec0, 0);
      check("rst_updb1", updb1, 0);
      check("rst_dndb1", dndb1, 0);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // single press, no repeat
      raw[0] = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         check("s1_inc", inc0, e == 7);
         check("s1_updb", updb0, e >= 6);
      end
      raw[0] = 1'b0;
      repeat (15) @(negedge clk);

      // fast bounce and 3-cycle glitches
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         raw[0] = ~i[0];
         check("s2_bounce_db", updb0, 0);
      end
      for (int g = 0; g < 3; g++) begin
         @(negedge clk) raw[0] = 1'b0;
         repeat (4) @(negedge clk);
         raw[0] = 1'b1;
         repeat (3) @(negedge clk);
         raw[0] = 1'b0;
         repeat (4) begin
            @(negedge clk);
            check("s2_glitch_db", updb0, 0);
         end
      end
      @(negedge clk) raw[0] = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         @(posedge clk); #1;
         check("s2_inc", inc0, e == 7);
      end
      raw[0] = 1'b0;
      repeat (15) @(negedge clk);

      // hold down with auto-repeat
      raw[1] = 1'b1;
      for (int e = 1; e <= 55; e++) begin
         @(posedge clk); #1;
         check("s3_dec1", dec1, (e == 7) ||
               (e >= 17 && e < 47 && ((e - 17) % 5) == 0));
         check("s3_dec0", dec0, e == 7);
         if (e == 40) raw[1] = 1'b0;
      end
      repeat (10) @(negedge clk);

      // conflicting press while up repeats
      raw[0] = 1'b1;
      repeat (20) @(negedge clk);
      raw[1] = 1'b1;
      nd = 0; nsup = 0; nres = 0;
      prev_dn = dndb1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (dec1) nd++;
         if (inc1 && prev_dn) nsup++;
         prev_dn = dndb1;
      end
      @(negedge clk) raw[1] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (dec1) nd++;
         if (inc1 && prev_dn) nsup++;
         if (inc1 && !prev_dn && !dndb1) nres++;
         prev_dn = dndb1;
      end
      check("s4_no_dec", nd, 0);
      check("s4_suppressed", nsup, 0);
      check("s4_resume", nres > 0, 1);
      @(negedge clk) raw[0] = 1'b0;
      repeat (15) @(negedge clk);

      // reset during HOLD
      raw[0] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("s5_inc0", inc0, 0);
      check("s5_updb0", updb0, 0);
      check("s5_inc1", inc1, 0);
      check("s5_updb1", updb1, 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         check("s5_inc", inc0, e == 7);
      end
      raw[0] = 1'b0;
      repeat (15) @(negedge clk);

      // alternating press/release trains
      b0 = n_inc0; b1 = n_dec0; b2 = n_inc1; b3 = n_dec1;
      for (int i = 0; i < 10; i++) begin
         raw[0] = 1'b1;
         repeat (8) @(negedge clk);
         raw[0] = 1'b0;
         repeat (8) @(negedge clk);
         raw[1] = 1'b1;
         repeat (8) @(negedge clk);
         raw[1] = 1'b0;
         repeat (8) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      check("s6_inc0", n_inc0 - b0, 10);
      check("s6_dec0", n_dec0 - b1, 10);
      check("s6_inc1", n_inc1 - b2, 10);
      check("s6_dec1", n_dec1 - b3, 10);

      // random presses, holds and resets
      for (int s = 0; s < 200; s++) begin
         raw[0] = 1'($urandom_range(0, 1));
         raw[1] = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 40)) @(negedge clk);
         if ($urandom_range(0, 19) == 0) begin
            #1 rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
         end
      end
      raw = 2'b00;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
